// File: rtl/cmsdk_uart_stim_tx_if.sv
// cmsdk_uart_stim_tx_if : push-side valid/ready channel of the UART stimulus transmitter
// Rev 1.0
`default_nettype none

interface cmsdk_uart_stim_tx_if;
    logic [7:0] DATA_IN;
    logic       ESC_PREFIX;
    logic       DATA_VALID;
    logic       DATA_READY;

    modport master (
        output DATA_IN,
        output ESC_PREFIX,
        output DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  DATA_IN,
        input  ESC_PREFIX,
        input  DATA_VALID,
        output DATA_READY
    );
endinterface

`default_nettype wire

// File: rtl/cmsdk_uart_stim_tx.sv
// cmsdk_uart_stim_tx : FIFO-fed 8N1 serial transmitter with optional ESC prefix frame
// Rev 1.0
`default_nettype none

module cmsdk_uart_stim_tx #(
    parameter int FIFO_AW   = 3,
    parameter int STOP_BITS = 1,
    parameter int IDLE_GAP  = 0
) (
    input  wire logic                 CLK,
    input  wire logic                 RESETn,
    cmsdk_uart_stim_tx_if.slave       push,
    input  wire logic                 TX_ENABLE,
    output logic                      TXD,
    output logic                      BUSY,
    output logic                      TX_DONE,
    output logic [FIFO_AW:0]          FIFO_LEVEL
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [8:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     level_q;
    logic [7:0]           hold_q, hold_d;
    logic                 esc_q, esc_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 push_w, pop_w, frame_end_w;

    assign push.DATA_READY = (level_q != (FIFO_AW+1)'(DEPTH));
    assign push_w          = push.DATA_VALID & push.DATA_READY;
    assign pop_w           = (state_q == IDLE) & (level_q != '0) & TX_ENABLE;

    // TXD is registered so it rests glitch-free and is forced high by reset asynchronously
    assign TXD        = txd_q;
    assign TX_DONE    = done_q;
    assign FIFO_LEVEL = level_q;
    assign BUSY       = (state_q != IDLE) | (level_q != '0);

    always_ff @(posedge CLK) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= {push.ESC_PREFIX, push.DATA_IN};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + (FIFO_AW+1)'(push_w) - (FIFO_AW+1)'(pop_w);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            hold_q  <= '0;
            esc_q   <= 1'b0;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            esc_q   <= esc_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        esc_d       = esc_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        txd_d       = 1'b1;
        done_d      = 1'b0;
        frame_end_w = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop_w) begin
                    hold_d  = mem_q[rd_ptr_q][7:0];
                    esc_d   = mem_q[rd_ptr_q][8];
                    state_d = START;
                end
            end
            START: begin
                txd_d   = 1'b0;
                shift_d = esc_q ? 8'h1B : hold_q;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                txd_d   = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                cnt_d   = '0;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(STOP_BITS - 1)) begin
                    if (IDLE_GAP > 0) begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        frame_end_w = 1'b1;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(IDLE_GAP - 1)) frame_end_w = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // An ESC prefix chains straight into its data frame, ignoring TX_ENABLE
        if (frame_end_w) begin
            if (esc_q) begin
                esc_d   = 1'b0;
                state_d = START;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmsdk_uart_stim_tx.sv
// tb_cmsdk_uart_stim_tx : two transmitter configurations against a bit-stream reference model
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_cmsdk_uart_stim_tx;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    logic [7:0] din  = 8'h00;
    logic       desc = 1'b0;
    logic       dvld = 1'b0;
    logic       txen = 1'b0;

    logic [1:0]        txd_v, busy_v, done_v, rdy_v;
    logic [1:0][AW:0]  lev_v;

    int n_vec = 0;
    int n_err = 0;

    cmsdk_uart_stim_tx_if p0 ();
    cmsdk_uart_stim_tx_if p1 ();

    assign p0.DATA_IN = din;  assign p0.ESC_PREFIX = desc;  assign p0.DATA_VALID = dvld;
    assign p1.DATA_IN = din;  assign p1.ESC_PREFIX = desc;  assign p1.DATA_VALID = dvld;
    assign rdy_v = {p1.DATA_READY, p0.DATA_READY};

    cmsdk_uart_stim_tx #(.FIFO_AW(AW), .STOP_BITS(1), .IDLE_GAP(0)) u_dut0 (
        .CLK(CLK), .RESETn(RESETn), .push(p0.slave), .TX_ENABLE(txen),
        .TXD(txd_v[0]), .BUSY(busy_v[0]), .TX_DONE(done_v[0]), .FIFO_LEVEL(lev_v[0])
    );

    cmsdk_uart_stim_tx #(.FIFO_AW(AW), .STOP_BITS(2), .IDLE_GAP(3)) u_dut1 (
        .CLK(CLK), .RESETn(RESETn), .push(p1.slave), .TX_ENABLE(txen),
        .TXD(txd_v[1]), .BUSY(busy_v[1]), .TX_DONE(done_v[1]), .FIFO_LEVEL(lev_v[1])
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: FIFO of entries + committed line waveform
    logic [8:0] mf [2][DEPTH];
    int  mrd [2], mwr [2], mlev [2];
    bit  st_txd [2][64];
    bit  st_done[2][64];
    int  shd [2], scn [2];
    bit  e_txd [2], e_done [2];
    bit  model_ok = 1'b0;

    function automatic int sbits(int i); return (i == 1) ? 2 : 1; endfunction
    function automatic int gbits(int i); return (i == 1) ? 3 : 0; endfunction

    task automatic put_bit(int i, bit b, bit dn);
        st_txd [i][(shd[i] + scn[i]) % 64] = b;
        st_done[i][(shd[i] + scn[i]) % 64] = dn;
        scn[i]++;
    endtask

    task automatic put_frame(int i, logic [7:0] d, bit last_done);
        int ones;
        ones = sbits(i) + gbits(i);
        put_bit(i, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) put_bit(i, d[b], 1'b0);
        for (int k = 0; k < ones; k++) put_bit(i, 1'b1, last_done && (k == ones - 1));
    endtask

    task automatic model_reset(int i);
        mrd[i] = 0; mwr[i] = 0; mlev[i] = 0; shd[i] = 0; scn[i] = 0;
        e_txd[i] = 1'b1; e_done[i] = 1'b0;
    endtask

    task automatic model_step(int i);
        bit do_push, do_pop;
        logic [8:0] ent;
        do_push = dvld && (mlev[i] != DEPTH);
        do_pop  = (scn[i] == 0) && (mlev[i] != 0) && txen;
        if (do_pop) begin
            ent    = mf[i][mrd[i]];
            mrd[i] = (mrd[i] + 1) % DEPTH;
            put_bit(i, 1'b1, 1'b0);
            if (ent[8]) put_frame(i, 8'h1B, 1'b0);
            put_frame(i, ent[7:0], 1'b1);
        end
        if (do_push) begin
            mf[i][mwr[i]] = {desc, din};
            mwr[i] = (mwr[i] + 1) % DEPTH;
        end
        mlev[i] = mlev[i] + int'(do_push) - int'(do_pop);
        if (scn[i] != 0) begin
            e_txd[i]  = st_txd [i][shd[i]];
            e_done[i] = st_done[i][shd[i]];
            shd[i]    = (shd[i] + 1) % 64;
            scn[i]--;
        end else begin
            e_txd[i]  = 1'b1;
            e_done[i] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RESETn);
            for (int i = 0; i < 2; i++) begin
                if (!RESETn) model_reset(i);
                else         model_step(i);
            end
            model_ok = 1'b1;
        end
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (model_ok) begin
                for (int i = 0; i < 2; i++) begin
                    chk("txd",   i, 32'(txd_v[i]),  32'(e_txd[i]));
                    chk("done",  i, 32'(done_v[i]), 32'(e_done[i]));
                    chk("busy",  i, 32'(busy_v[i]), 32'((scn[i] != 0) || (mlev[i] != 0)));
                    chk("ready", i, 32'(rdy_v[i]),  32'(mlev[i] != DEPTH));
                    chk("level", i, 32'(lev_v[i]),  32'(mlev[i]));
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_one(logic [7:0] d, bit e);
        int n;
        din = d; desc = e; dvld = 1'b1;
        n = 0;
        while (!p0.DATA_READY && n < 200) begin tick(); n++; end
        if (n >= 200) chk("push_timeout", 0, 32'd1, 32'd0);
        tick();
        dvld = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((busy_v != 2'b00) && n < budget) begin tick(); n++; end
        chk("idle_timeout", 0, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_start(int i, int budget);
        int n;
        n = 0;
        while (txd_v[i] != 1'b0 && n < budget) begin tick(); n++; end
        chk("start_timeout", i, 32'(n >= budget), 32'd0);
    endtask

    logic [29:0] cap;
    int          dcnt;

    initial begin
        repeat (3) tick();
        chk("rst_txd",   0, 32'(txd_v[0]),  32'd1);
        chk("rst_ready", 0, 32'(rdy_v[0]),  32'd1);
        chk("rst_busy",  0, 32'(busy_v[0]), 32'd0);
        chk("rst_done",  0, 32'(done_v[0]), 32'd0);
        chk("rst_level", 0, 32'(lev_v[0]),  32'd0);
        #2 RESETn = 1'b1;
        tick();

        // single plain character
        txen = 1'b1;
        push_one(8'h41, 1'b0);
        tick();
        cap = '0; dcnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            cap  = {cap[28:0], txd_v[0]};
            dcnt += int'(done_v[0]);
        end
        chk("frame_41", 0, 32'(cap[9:0]), 32'(10'b0100000101));
        chk("done_41",  0, 32'(dcnt), 32'd1);
        tick();
        chk("busy_after_41", 0, 32'(busy_v[0]), 32'd0);
        wait_idle(200);

        // ESC-prefixed entry goes out as two contiguous frames
        push_one(8'h11, 1'b1);
        tick();
        cap = '0; dcnt = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            cap  = {cap[28:0], txd_v[0]};
            dcnt += int'(done_v[0]);
        end
        chk("frame_esc11", 0, 32'(cap[19:0]), 32'(20'b0110110001_0100010001));
        chk("done_esc11",  0, 32'(dcnt), 32'd1);
        wait_idle(300);

        // fill to full with transmission held off
        txen = 1'b0;
        for (int c = 0; c < 8; c++) push_one(8'h30 + 8'(c), 1'b0);
        chk("full_level", 0, 32'(lev_v[0]), 32'd8);
        chk("full_ready", 0, 32'(rdy_v[0]), 32'd0);
        din = 8'h38; desc = 1'b0; dvld = 1'b1; txen = 1'b1;
        tick();
        chk("pop_level", 0, 32'(lev_v[0]), 32'd7);
        chk("pop_ready", 0, 32'(rdy_v[0]), 32'd1);
        tick();
        dvld = 1'b0;
        chk("ninth_level", 0, 32'(lev_v[0]), 32'd8);
        wait_idle(2000);

        // stop bits + idle gap on the second instance
        push_one(8'h55, 1'b0);
        push_one(8'h55, 1'b0);
        wait_start(1, 50);
        cap = {29'd0, txd_v[1]};
        for (int j = 1; j < 30; j++) begin
            tick();
            cap = {cap[28:0], txd_v[1]};
        end
        chk("frame_55_gap", 1, 32'(cap), 32'(30'b01010101011111_1_01010101011111_1));
        wait_idle(300);

        // TX_ENABLE dropped during the ESC prefix frame
        push_one(8'h04, 1'b1);
        push_one(8'h22, 1'b0);
        wait_start(0, 50);
        repeat (3) tick();
        txen = 1'b0;
        dcnt = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            dcnt += int'(done_v[0]);
        end
        chk("esc_hold_done",  0, 32'(dcnt), 32'd1);
        chk("esc_hold_level", 0, 32'(lev_v[0]), 32'd1);
        txen = 1'b1;
        wait_idle(300);

        // asynchronous reset in the middle of data bit 4
        txen = 1'b0;
        for (int c = 0; c < 4; c++) push_one(8'h61 + 8'(c), 1'b0);
        txen = 1'b1;
        wait_start(0, 50);
        repeat (5) tick();
        #2 RESETn = 1'b0;
        #1;
        chk("arst_txd0",  0, 32'(txd_v[0]),  32'd1);
        chk("arst_txd1",  1, 32'(txd_v[1]),  32'd1);
        chk("arst_level", 0, 32'(lev_v[0]),  32'd0);
        chk("arst_busy",  0, 32'(busy_v[0]), 32'd0);
        chk("arst_done",  0, 32'(done_v[0]), 32'd0);
        repeat (2) tick();
        #2 RESETn = 1'b1;
        dcnt = 0; cap = '1;
        for (int j = 0; j < 20; j++) begin
            tick();
            dcnt += int'(done_v[0]);
            cap  = {cap[28:0], txd_v[0]};
        end
        chk("post_rst_done", 0, 32'(dcnt), 32'd0);
        chk("post_rst_txd",  0, 32'(cap[19:0]), 32'hFFFFF);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            dvld = 1'($urandom_range(0, 1));
            din  = 8'($urandom_range(0, 255));
            desc = ($urandom_range(0, 3) == 0);
            txen = ($urandom_range(0, 7) != 0);
            tick();
        end
        dvld = 1'b0;
        txen = 1'b1;
        wait_idle(3000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
